// File: rtl/emio_btn_pkg.sv
// Shared types and EMIO bit positions for the button conditioner.
// The FSM state enum lives here so every per-button instance uses the same encoding.
package emio_btn_pkg;

   localparam int NUM_BTN_DEFAULT = 4;
   localparam int MAX_PACKED_BTN  = 4;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } btn_state_e;

   // Fields of the status word returned to the PS on EMIOGPIOI
   localparam int GPIO_I_LEVEL_LSB = 0;
   localparam int GPIO_I_FLAG_LSB  = 4;
   localparam int GPIO_I_CNT_LSB   = 8;
   localparam int GPIO_I_CNT_W     = 8;

   // Control strobes written by the PS on EMIOGPIOO
   localparam int GPIO_O_ACK_LSB   = 4;
   localparam int GPIO_O_CLR_LSB   = 8;

endpackage

// File: rtl/emio_btn_debounce.sv
// One button: 2-flop synchronizer, 4-state debounce FSM with stability counter,
// registered debounced level and a one-cycle press pulse on each committed rising edge.
module emio_btn_debounce
   import emio_btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level,
   output logic press
);

   // The cycle that enters WAIT already counts as the first stable cycle, so the
   // commit fires on the edge where the counter would step to DEBOUNCE_CYCLES-1.
   localparam logic [15:0] COMMIT_AT = 16'(DEBOUNCE_CYCLES - 2);

   logic [1:0]  sync_q;
   logic        raw_s;
   btn_state_e  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;

   assign raw_s = sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         level   <= 1'b0;
         press   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level   <= (state_d == STABLE_HI) || (state_d == WAIT_LO);
         press   <= (state_q == WAIT_HI) && (state_d == STABLE_HI);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         STABLE_LO: begin
            if (raw_s) begin
               state_d = WAIT_HI;
               cnt_d   = '0;
            end
         end
         WAIT_HI: begin
            if (!raw_s) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == COMMIT_AT) state_d = STABLE_HI;
            end
         end
         STABLE_HI: begin
            if (!raw_s) begin
               state_d = WAIT_LO;
               cnt_d   = '0;
            end
         end
         WAIT_LO: begin
            if (raw_s) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == COMMIT_AT) state_d = STABLE_LO;
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/emio_btn_conditioner.sv
// Debounced board buttons exposed to the PS7 over EMIO: levels, sticky press flags
// and 8-bit press counters, with ack/clear strobes coming back on EMIOGPIOO.
module emio_btn_conditioner
   import emio_btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int NUM_BTN         = NUM_BTN_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn,
   input  logic [63:0]        emio_gpio_o,
   output logic [63:0]        emio_gpio_i,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press
);

   localparam int NUM_PACK = (NUM_BTN < MAX_PACKED_BTN) ? NUM_BTN : MAX_PACKED_BTN;

   logic [MAX_PACKED_BTN-1:0] ack_now, ack_q, ack_rise;
   logic [MAX_PACKED_BTN-1:0] clr_now, clr_q, clr_rise;
   logic [NUM_PACK-1:0]       flag_q;
   logic [GPIO_I_CNT_W-1:0]   press_cnt_q [NUM_PACK];
   logic                      unused_gpio_o;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      emio_btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .rst_n (rst_n),
         .btn   (btn[g]),
         .level (btn_level[g]),
         .press (btn_press[g])
      );
   end

   // EMIOGPIOO is already in the clk domain; only a one-cycle history is kept for edges
   assign ack_now  = emio_gpio_o[GPIO_O_ACK_LSB +: MAX_PACKED_BTN];
   assign clr_now  = emio_gpio_o[GPIO_O_CLR_LSB +: MAX_PACKED_BTN];
   assign ack_rise = ack_now & ~ack_q;
   assign clr_rise = clr_now & ~clr_q;
   assign unused_gpio_o = ^{emio_gpio_o[63:GPIO_O_CLR_LSB+MAX_PACKED_BTN],
                            emio_gpio_o[GPIO_O_ACK_LSB-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q  <= '0;
         clr_q  <= '0;
         flag_q <= '0;
         for (int i = 0; i < NUM_PACK; i++) press_cnt_q[i] <= '0;
      end else begin
         ack_q <= ack_now;
         clr_q <= clr_now;
         for (int i = 0; i < NUM_PACK; i++) begin
            // A press arriving with the ack must not be lost, so set beats clear
            if (btn_press[i])     flag_q[i] <= 1'b1;
            else if (ack_rise[i]) flag_q[i] <= 1'b0;

            if (clr_rise[i])       press_cnt_q[i] <= btn_press[i] ? 8'd1 : 8'd0;
            else if (btn_press[i]) press_cnt_q[i] <= press_cnt_q[i] + 8'd1;
         end
      end
   end

   // Pure wiring of flop outputs, so the status word stays registered
   always_comb begin
      emio_gpio_i = '0;
      for (int i = 0; i < NUM_PACK; i++) begin
         emio_gpio_i[GPIO_I_LEVEL_LSB + i] = btn_level[i];
         emio_gpio_i[GPIO_I_FLAG_LSB + i]  = flag_q[i];
         emio_gpio_i[GPIO_I_CNT_LSB + GPIO_I_CNT_W*i +: GPIO_I_CNT_W] = press_cnt_q[i];
      end
   end

endmodule
